// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - debug, jump, instruction-memory and issue signals of the fetch sequencer
interface fetch_sequencer_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   run;
    logic                   halt_request;
    logic                   step;
    logic                   bp_enable;
    logic [7:0]             bp_address;
    logic                   jump_valid;
    logic [7:0]             jump_target;
    logic [7:0]             mem_address;
    logic [31:0]            mem_instruction;
    logic [31:0]            instr;
    logic                   instr_valid;
    logic [7:0]             instr_pc;
    logic                   halted;
    logic                   at_breakpoint;
    logic [COUNT_WIDTH-1:0] retired_count;

    modport master (
        input  run, halt_request, step, bp_enable, bp_address,
        input  jump_valid, jump_target, mem_instruction,
        output mem_address, instr, instr_valid, instr_pc,
        output halted, at_breakpoint, retired_count
    );

    modport slave (
        output run, halt_request, step, bp_enable, bp_address,
        output jump_valid, jump_target, mem_instruction,
        input  mem_address, instr, instr_valid, instr_pc,
        input  halted, at_breakpoint, retired_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter, issue register and debug halt/step/breakpoint control
module fetch_sequencer #(
    parameter logic [7:0] RESET_PC     = 8'd0,
    parameter bit         START_HALTED = 1'b0,
    parameter int         COUNT_WIDTH  = 16
) (
    input  logic               clock,
    input  logic               reset,
    fetch_sequencer_if.master  bus
);
    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_RUN   = 2'd1,
        S_BREAK = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [7:0]             pc;
    logic [31:0]            instr_q;
    logic                   instr_valid_q;
    logic [7:0]             instr_pc_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   armed;

    logic                   take_jump;
    logic                   bp_hit;
    logic                   issue;
    logic                   halted_o;
    logic                   at_bp_o;

    // A jump is only real when the instruction carrying it is live.
    assign take_jump = bus.jump_valid && instr_valid_q;
    assign bp_hit    = bus.bp_enable && (pc == bus.bp_address) && armed;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= START_HALTED ? S_HALT : S_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RUN: begin
                if (bus.halt_request) begin
                    state_next = S_HALT;
                end else if (!take_jump && bp_hit) begin
                    state_next = S_BREAK;
                end
            end
            S_HALT, S_BREAK: begin
                // A step in the same cycle as run wins; the run is dropped.
                if (!bus.step && bus.run && !bus.halt_request) begin
                    state_next = S_RUN;
                end
            end
            default: state_next = S_HALT;
        endcase
    end

    always_comb begin
        issue    = 1'b0;
        halted_o = 1'b1;
        at_bp_o  = 1'b0;
        case (state)
            S_RUN: begin
                halted_o = 1'b0;
                issue    = !take_jump && !bus.halt_request && !bp_hit;
            end
            S_BREAK: begin
                at_bp_o = 1'b1;
                issue   = bus.step && !take_jump;
            end
            default: begin
                issue = bus.step && !take_jump;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc            <= RESET_PC;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            instr_pc_q    <= 8'd0;
            count_q       <= '0;
            armed         <= 1'b0;
        end else begin
            instr_valid_q <= issue;
            if (take_jump) begin
                pc <= bus.jump_target;
            end else if (issue) begin
                pc <= pc + 8'd1;
            end
            if (issue) begin
                instr_q    <= bus.mem_instruction;
                instr_pc_q <= pc;
                if (count_q != {COUNT_WIDTH{1'b1}}) begin
                    count_q <= count_q + COUNT_WIDTH'(1);
                end
            end
            // Armed only by a RUN issue, so resuming skips the trap once.
            if (state != S_RUN) begin
                armed <= 1'b0;
            end else if (issue) begin
                armed <= 1'b1;
            end
        end
    end

    assign bus.mem_address   = pc;
    assign bus.instr         = instr_q;
    assign bus.instr_valid   = instr_valid_q;
    assign bus.instr_pc      = instr_pc_q;
    assign bus.halted        = halted_o;
    assign bus.at_breakpoint = at_bp_o;
    assign bus.retired_count = count_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench: free run, breakpoints, stepping, jump races, wrap, saturation, reset
module tb_fetch_sequencer;
    logic clock = 1'b0;
    logic rst0  = 1'b1;
    logic rst1  = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [8:0] exp_q[$];

    always #5 clock = ~clock;

    fetch_sequencer_if #(.COUNT_WIDTH(16)) b0();
    fetch_sequencer_if #(.COUNT_WIDTH(4))  b1();

    fetch_sequencer #(.RESET_PC(8'd0), .START_HALTED(1'b0), .COUNT_WIDTH(16)) u0 (
        .clock(clock), .reset(rst0), .bus(b0));
    fetch_sequencer #(.RESET_PC(8'd254), .START_HALTED(1'b1), .COUNT_WIDTH(4)) u1 (
        .clock(clock), .reset(rst1), .bus(b1));

    // Program: address 10 is JMP 5, everything else a non-jump tagged with its address.
    function automatic logic [31:0] mem_f(input logic [7:0] a);
        return (a == 8'd10) ? 32'hF000_0005 : {24'h100000, a};
    endfunction

    assign b0.mem_instruction = mem_f(b0.mem_address);
    assign b1.mem_instruction = mem_f(b1.mem_address);
    assign b0.jump_valid      = b0.instr_valid && (b0.instr[31:28] == 4'hF);
    assign b1.jump_valid      = b1.instr_valid && (b1.instr[31:28] == 4'hF);
    assign b0.jump_target     = b0.instr[7:0];
    assign b1.jump_target     = b1.instr[7:0];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset0();
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
    endtask

    task automatic wait_jmp0(input string name);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            found = b0.instr_valid && (b0.instr_pc == 8'd10);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_wait: JMP never issued within 40 cycles, required issue at pc 10", name);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks += 6;
        if (b0.instr_valid !== 1'b0 || b0.instr !== 32'd0 || b0.instr_pc !== 8'd0) begin
            errors++;
            $display("FAIL reset_issue: valid=%b instr=%h pc=%0d, required 0/0/0", b0.instr_valid, b0.instr, b0.instr_pc);
        end
        if (b0.retired_count !== 16'd0 || b0.mem_address !== 8'd0) begin
            errors++;
            $display("FAIL reset_pc_count: count=%0d addr=%0d, required 0/0", b0.retired_count, b0.mem_address);
        end
        if (b0.halted !== 1'b0 || b0.at_breakpoint !== 1'b0) begin
            errors++;
            $display("FAIL reset_run_state: halted=%b at_bp=%b, required 0/0", b0.halted, b0.at_breakpoint);
        end
        if (b1.halted !== 1'b1 || b1.at_breakpoint !== 1'b0) begin
            errors++;
            $display("FAIL reset_halt_state: halted=%b at_bp=%b, required 1/0", b1.halted, b1.at_breakpoint);
        end
        if (b1.mem_address !== 8'd254) begin
            errors++;
            $display("FAIL reset_pc_param: addr=%0d, required 254", b1.mem_address);
        end
        if (b1.instr_valid !== 1'b0 || b1.retired_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_u1: valid=%b count=%0d, required 0/0", b1.instr_valid, b1.retired_count);
        end
        rst0 = 1'b0;
        rst1 = 1'b0;
    endtask

    task automatic test_free_run();
        logic [8:0] e;
        int n = 0;
        for (int p = 0; p <= 10; p++) exp_q.push_back({1'b1, 8'(p)});
        exp_q.push_back(9'h0);
        for (int p = 5; p <= 10; p++) exp_q.push_back({1'b1, 8'(p)});
        exp_q.push_back(9'h0);
        exp_q.push_back({1'b1, 8'd5});
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (b0.instr_valid !== e[8] || (e[8] && (b0.instr_pc !== e[7:0] || b0.instr !== mem_f(e[7:0])))) begin
                errors++;
                $display("FAIL free_run[%0d]: valid=%b pc=%0d instr=%h, required valid=%b pc=%0d", n, b0.instr_valid, b0.instr_pc, b0.instr, e[8], e[7:0]);
            end
            if (n == 10) begin
                checks++;
                if (b0.retired_count !== 16'd11) begin
                    errors++;
                    $display("FAIL free_run_count: count=%0d, required 11", b0.retired_count);
                end
            end
            n++;
        end
    endtask

    task automatic test_breakpoint();
        logic [8:0] e;
        reset0();
        b0.bp_enable  = 1'b1;
        b0.bp_address = 8'd7;
        for (int p = 0; p <= 6; p++) exp_q.push_back({1'b1, 8'(p)});
        exp_q.push_back(9'h0);
        exp_q.push_back(9'h0);
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (b0.instr_valid !== e[8] || (e[8] && b0.instr_pc !== e[7:0])) begin
                errors++;
                $display("FAIL bp_trap_seq: valid=%b pc=%0d, required valid=%b pc=%0d", b0.instr_valid, b0.instr_pc, e[8], e[7:0]);
            end
        end
        checks++;
        if (b0.halted !== 1'b1 || b0.at_breakpoint !== 1'b1 || b0.mem_address !== 8'd7) begin
            errors++;
            $display("FAIL bp_state: halted=%b at_bp=%b addr=%0d, required 1/1/7", b0.halted, b0.at_breakpoint, b0.mem_address);
        end
        b0.run = 1'b1;
        tick();
        b0.run = 1'b0;
        checks++;
        if (b0.instr_valid !== 1'b0 || b0.halted !== 1'b0) begin
            errors++;
            $display("FAIL bp_resume: valid=%b halted=%b, required 0/0", b0.instr_valid, b0.halted);
        end
        for (int p = 7; p <= 10; p++) exp_q.push_back({1'b1, 8'(p)});
        exp_q.push_back(9'h0);
        exp_q.push_back({1'b1, 8'd5});
        exp_q.push_back({1'b1, 8'd6});
        exp_q.push_back(9'h0);
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (b0.instr_valid !== e[8] || (e[8] && b0.instr_pc !== e[7:0])) begin
                errors++;
                $display("FAIL bp_resume_seq: valid=%b pc=%0d, required valid=%b pc=%0d", b0.instr_valid, b0.instr_pc, e[8], e[7:0]);
            end
        end
        checks++;
        if (b0.at_breakpoint !== 1'b1 || b0.mem_address !== 8'd7) begin
            errors++;
            $display("FAIL bp_retrap: at_bp=%b addr=%0d, required 1/7", b0.at_breakpoint, b0.mem_address);
        end
        b0.bp_enable = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [8:0] e;
        reset0();
        wait_jmp0("halt_jump");
        b0.halt_request = 1'b1;
        tick();
        b0.halt_request = 1'b0;
        checks++;
        if (b0.mem_address !== 8'd5 || b0.halted !== 1'b1 || b0.instr_valid !== 1'b0 || b0.retired_count !== 16'd11) begin
            errors++;
            $display("FAIL halt_jump: addr=%0d halted=%b valid=%b count=%0d, required 5/1/0/11", b0.mem_address, b0.halted, b0.instr_valid, b0.retired_count);
        end
        for (int p = 5; p <= 10; p++) begin
            exp_q.push_back({1'b1, 8'(p)});
            exp_q.push_back(9'h0);
        end
        while (exp_q.size() > 0) begin
            b0.step = exp_q[0][8];
            tick();
            b0.step = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (b0.instr_valid !== e[8] || (e[8] && b0.instr_pc !== e[7:0]) || b0.halted !== 1'b1) begin
                errors++;
                $display("FAIL step_seq: valid=%b pc=%0d halted=%b, required valid=%b pc=%0d halted=1", b0.instr_valid, b0.instr_pc, b0.halted, e[8], e[7:0]);
            end
        end
        checks++;
        if (b0.mem_address !== 8'd5 || b0.retired_count !== 16'd17) begin
            errors++;
            $display("FAIL step_jmp: addr=%0d count=%0d, required 5/17", b0.mem_address, b0.retired_count);
        end
        reset0();
        wait_jmp0("bp_jump");
        b0.bp_enable  = 1'b1;
        b0.bp_address = 8'd5;
        tick();
        checks++;
        if (b0.instr_valid !== 1'b0 || b0.halted !== 1'b0 || b0.mem_address !== 8'd5) begin
            errors++;
            $display("FAIL bp_jump_bubble: valid=%b halted=%b addr=%0d, required 0/0/5", b0.instr_valid, b0.halted, b0.mem_address);
        end
        tick();
        checks++;
        if (b0.instr_valid !== 1'b0 || b0.at_breakpoint !== 1'b1 || b0.mem_address !== 8'd5) begin
            errors++;
            $display("FAIL bp_jump_trap: valid=%b at_bp=%b addr=%0d, required 0/1/5", b0.instr_valid, b0.at_breakpoint, b0.mem_address);
        end
        b0.bp_enable = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        reset0();
        wait_jmp0("reset_mid");
        rst0 = 1'b1;
        tick();
        checks++;
        if (b0.mem_address !== 8'd0 || b0.instr !== 32'd0 || b0.instr_valid !== 1'b0 || b0.retired_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid: addr=%0d instr=%h valid=%b count=%0d, required 0/0/0/0", b0.mem_address, b0.instr, b0.instr_valid, b0.retired_count);
        end
        rst0 = 1'b0;
        tick();
        checks++;
        if (b0.instr_valid !== 1'b1 || b0.instr_pc !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_nojump: valid=%b pc=%0d, required 1/0", b0.instr_valid, b0.instr_pc);
        end
    endtask

    task automatic test_wrap_saturate();
        logic [8:0] e;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({1'b1, 8'(254 + k)});
            exp_q.push_back(9'h0);
        end
        while (exp_q.size() > 0) begin
            b1.step = exp_q[0][8];
            tick();
            b1.step = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (b1.instr_valid !== e[8] || (e[8] && (b1.instr_pc !== e[7:0] || b1.instr !== mem_f(e[7:0]))) || b1.halted !== 1'b1) begin
                errors++;
                $display("FAIL wrap_step: valid=%b pc=%0d halted=%b, required valid=%b pc=%0d halted=1", b1.instr_valid, b1.instr_pc, b1.halted, e[8], e[7:0]);
            end
        end
        b1.run = 1'b1;
        tick();
        b1.run = 1'b0;
        for (int p = 1; p <= 10; p++) exp_q.push_back({1'b1, 8'(p)});
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (b1.instr_valid !== e[8] || b1.instr_pc !== e[7:0]) begin
                errors++;
                $display("FAIL wrap_run: valid=%b pc=%0d, required valid=%b pc=%0d", b1.instr_valid, b1.instr_pc, e[8], e[7:0]);
            end
        end
        checks++;
        if (b1.retired_count !== 4'd13) begin
            errors++;
            $display("FAIL count_pre_sat: count=%0d, required 13", b1.retired_count);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (b1.retired_count !== 4'd15) begin
            errors++;
            $display("FAIL count_saturate: count=%0d, required 15", b1.retired_count);
        end
    endtask

    initial begin
        b0.run = 1'b0; b0.halt_request = 1'b0; b0.step = 1'b0; b0.bp_enable = 1'b0; b0.bp_address = 8'd0;
        b1.run = 1'b0; b1.halt_request = 1'b0; b1.step = 1'b0; b1.bp_enable = 1'b0; b1.bp_address = 8'd0;
        test_reset();
        test_free_run();
        test_breakpoint();
        test_simultaneous();
        test_reset_mid_run();
        test_wrap_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1);
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter controller that sequences the combinational instruction memory (8-bit address, 32-bit instruction word) and issues one registered instruction per cycle to the CPU decode/execute stage.
- Handles taken jumps from execute (one-cycle squash bubble), debug halt/run/single-step, and a single hardware breakpoint.
- Sits between instruction_memory and the CPU datapath; it is the only driver of the instruction memory address.

Parameters:
- RESET_PC, 8'd0, fetch address loaded on reset.
- START_HALTED, 0, 1 = leave reset in HALT; 0 = leave reset in RUN.
- COUNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; enter or stay in RUN while halted.
- halt_request  in  1  level; stop issuing.
- step  in  1  single-cycle pulse; issue exactly one instruction while halted.
- bp_enable  in  1  breakpoint enable.
- bp_address  in  8  breakpoint address.
- jump_valid  in  1  taken jump from execute; qualified by instr_valid.
- jump_target  in  8  jump destination.
- mem_address  out  8  instruction memory address; equals pc, combinational.
- mem_instruction  in  32  instruction memory data, combinational from mem_address.
- instr  out  32  issued instruction register.
- instr_valid  out  1  instr is live this cycle.
- instr_pc  out  8  address instr was fetched from.
- halted  out  1  state is HALT or BREAK.
- at_breakpoint  out  1  state is BREAK.
- retired_count  out  COUNT_WIDTH  count of issued (valid) instructions; saturating.

Behaviour:
- Reset (sync, highest priority):
  - pc = RESET_PC; instr = 32'd0 (NOP); instr_valid = 0; instr_pc = 0; retired_count = 0; armed = 0.
  - state = HALT if START_HALTED, else RUN.
  - Reset asserted mid-run discards any in-flight instruction and jump.
- States:
  - HALT: halted = 1.
  - RUN: halted = 0.
  - BREAK: halted = 1, at_breakpoint = 1.
- Issue (on any cycle that issues):
  - instr <= mem_instruction; instr_pc <= pc; instr_valid <= 1; pc <= pc + 1 (mod 256, so 255 wraps to 0); retired_count++ (saturates at all-ones).
  - Latency: address presented at cycle N appears on instr/instr_valid at cycle N+1.
- Jump:
  - Honoured only if jump_valid && instr_valid. pc <= jump_target; the fetch made this cycle is squashed (instr_valid <= 0 next cycle, no count).
  - Exactly one bubble per taken jump.
  - jump_valid while instr_valid = 0 is ignored.
  - A jump is honoured in every state. A jump is allowed after a step, so a stepped JMP updates pc.
- RUN, in priority order:
  - (1) Jump: jump action; state stays RUN, or becomes HALT if halt_request.
  - (2) halt_request: no issue, state becomes HALT, instr_valid <= 0.
  - (3) Breakpoint match (bp_enable && pc == bp_address && armed): no issue, state becomes BREAK, instr_valid <= 0.
  - (4) Otherwise: issue, armed <= 1.
- HALT/BREAK:
  - Default: instr_valid <= 0, pc holds, armed <= 0.
  - step: issue one instruction, state unchanged; a breakpoint never blocks a step.
  - run && !halt_request && !step: state becomes RUN. First issue occurs next cycle and is not breakpoint-checked (armed = 0), so resuming from BREAK executes the breakpoint instruction.
  - run and step in the same cycle: step is taken and run is ignored that cycle.
  - halt_request and run together: halt wins, stay halted.
- armed: set on each RUN issue; cleared whenever halted. It prevents re-trapping on resume only.
- Jump and breakpoint in the same cycle: jump wins. The breakpoint is evaluated against the new pc next cycle.
- mem_address is always pc, including while halted, so a debugger can read the next instruction.

Test Plan:
- Free run with JMP: START_HALTED = 0; memory holds 0..9 non-jump, 10 = JMP to 5; execute model drives jump_valid when instr is JMP. Release reset → instr_pc 0,1,…,10, one bubble (instr_valid = 0), then 5,6,…,10, bubble, 5. retired_count = 11 after the first JMP issue.
- Breakpoint and resume: bp_enable = 1, bp_address = 7, run held → issues 0..6, then BREAK with halted = 1, at_breakpoint = 1, pc = 7, instr_valid = 0. Pulse run for 1 cycle then hold low → continues 7, 8…; no re-trap at 7 until armed again; loops hitting 7 trap again.
- Single step: START_HALTED = 1, 3 step pulses → instr_pc 0,1,2, each valid for exactly one cycle, halted stays 1. Step onto JMP at 10 → pc = 5 afterwards.
- Simultaneous events: halt_request with a valid JMP → pc = target, state HALT, no issue. Breakpoint at 5 with a JMP to 5 in the same cycle → bubble, then BREAK at pc = 5.
- Wrap and saturation: RESET_PC = 254 with non-jump memory → instr_pc 254, 255, 0, 1. COUNT_WIDTH = 4 → retired_count saturates at 15.
- Reset mid-run: assert reset while instr_valid = 1 and jump_valid = 1 → next cycle pc = RESET_PC, instr = 0, instr_valid = 0, count = 0, and the jump is not taken.
